sdram_line_fill_arbiter: RTL

//  Shares one SDRAM read port between NUM_REQ line-fill caches (P/S/C/M ROM paths).
//  - Accepts whole-line fill requests and arbitrates them round-robin.
//  - Issues one burst command per grant, then routes the returned words to the granted cache.
//  - Sits between the per-ROM cache line blocks and the SDRAM controller read channel.

---
 rtl/sdram_line_fill_arbiter_pkg.sv | 10 +
 rtl/sdram_line_fill_arbiter_if.sv | 37 +++
 rtl/sdram_line_fill_arbiter_rr_pick.sv | 34 +++
 rtl/sdram_line_fill_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/sdram_line_fill_arbiter_pkg.sv
// Shared definitions for the SDRAM line-fill arbiter.
//  SDRAM_ADDR_W : default SDRAM word address width
//  LINE_WORDS   : default 16-bit words per cache line fill
//  fill_state_t : arbiter FSM state encoding
package neotang_sdram_pkg;
    localparam int SDRAM_ADDR_W = 25;
    localparam int LINE_WORDS   = 64;

    typedef enum logic [1:0] {IDLE, ISSUE, STREAM} fill_state_t;
endpackage

// File: rtl/sdram_line_fill_arbiter_if.sv
// Bus bundle between the line-fill caches, the arbiter and the SDRAM read channel.
//  req_*   : per-requester fill requests and accept pulses
//  rsp_*   : returned fill words routed to the granted requester
//  sdram_* : burst command and read-data channel of the SDRAM controller
//  slave modport = arbiter side, master modport = surrounding environment.
interface sdram_line_fill_arbiter_if
    import neotang_sdram_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LINE_WORDS = neotang_sdram_pkg::LINE_WORDS,
    parameter int ADDR_W     = SDRAM_ADDR_W
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [15:0]               rsp_data;
    logic [IDX_W-1:0]          rsp_idx;
    logic                      rsp_last;
    logic                      sdram_req;
    logic [ADDR_W-1:0]         sdram_addr;
    logic                      sdram_ack;
    logic                      sdram_dvalid;
    logic [15:0]               sdram_dout;

    modport slave (
        input  req_valid, req_addr, sdram_ack, sdram_dvalid, sdram_dout,
        output req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last, sdram_req, sdram_addr
    );

    modport master (
        output req_valid, req_addr, sdram_ack, sdram_dvalid, sdram_dout,
        input  req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last, sdram_req, sdram_addr
    );
endinterface

// File: rtl/sdram_line_fill_arbiter_rr_pick.sv
// Combinational round-robin picker.
//  req   : request vector
//  ptr   : index of the last served requester (lowest priority this round)
//  grant : one-hot, first set request scanning upward from ptr+1 with wrap
//  any   : at least one request present
module rr_pick
    import neotang_sdram_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any
);
    logic [PW:0] pos;

    // Walk from the farthest candidate (ptr itself) down to ptr+1 so the
    // nearest set request is the last one written and wins.
    always_comb begin
        grant = '0;
        pos   = '0;
        for (int k = N; k >= 1; k--) begin
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
            if (req[pos[PW-1:0]]) begin
                grant = '0;
                grant[pos[PW-1:0]] = 1'b1;
            end
        end
        any = |req;
    end
endmodule

// File: rtl/sdram_line_fill_arbiter.sv
// Shares one SDRAM burst-read port between NUM_REQ line-fill caches.
//  clk, rst_n   : system clock, synchronous active-low reset
//  bus          : request / response / SDRAM channel bundle (slave side)
//  busy         : high whenever a fill is being issued or streamed
//  err_spurious : sticky, SDRAM data seen while no burst was outstanding
// One grant = one burst command; returned words are registered once and
// steered to the granted requester with their word offset.
module sdram_line_fill_arbiter
    import neotang_sdram_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LINE_WORDS = neotang_sdram_pkg::LINE_WORDS,
    parameter int ADDR_W     = SDRAM_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sdram_line_fill_arbiter_if.slave  bus,
    output logic                      busy,
    output logic                      err_spurious
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int PW    = $clog2(NUM_REQ);

    fill_state_t        state;
    logic [NUM_REQ-1:0] grant, pick;
    logic               any;
    logic [PW-1:0]      ptr, pick_idx;
    logic [ADDR_W-1:0]  addr_q, sel_addr;
    logic [IDX_W-1:0]   count;
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [15:0]        rsp_data_q;
    logic [IDX_W-1:0]   rsp_idx_q;
    logic               rsp_last_q, sdram_req_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
        assign addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    end

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (pick),
        .any   (any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick[i]) pick_idx = PW'(i);
    end

    assign sel_addr = addr_arr[pick_idx];

    // Accept is same-cycle with the request seen in IDLE, so it is the only
    // combinational output; it is gated by reset so reset cycles stay quiet.
    assign bus.req_ready  = (state == IDLE && rst_n) ? pick : '0;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_idx    = rsp_idx_q;
    assign bus.rsp_last   = rsp_last_q;
    assign bus.sdram_req  = sdram_req_q;
    assign bus.sdram_addr = addr_q;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            ptr          <= PW'(NUM_REQ-1);
            addr_q       <= '0;
            count        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_idx_q    <= '0;
            rsp_last_q   <= 1'b0;
            sdram_req_q  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            rsp_last_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sdram_dvalid) err_spurious <= 1'b1;
                    if (any) begin
                        grant       <= pick;
                        ptr         <= pick_idx;
                        addr_q      <= {sel_addr[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
                        sdram_req_q <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.sdram_dvalid) err_spurious <= 1'b1;
                    if (bus.sdram_ack) begin
                        sdram_req_q <= 1'b0;
                        state       <= STREAM;
                    end
                end
                STREAM: begin
                    if (bus.sdram_dvalid) begin
                        rsp_valid_q <= grant;
                        rsp_data_q  <= bus.sdram_dout;
                        rsp_idx_q   <= count;
                        rsp_last_q  <= &count;
                        count       <= count + 1'b1;  // wraps to 0 after the last word
                        if (&count) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
